overture_pc_unit: RTL and testbench
===================================

Name: overture_pc_unit

Overview:
- Program-counter stage directly downstream of the CONDz_Compact condition evaluator.
- Consumes the evaluator's 1-bit Result together with the decoded instruction class, and produces the next fetch address.
- Handles sequential increment, conditional branch to the register-supplied target, and unconditional call/return through a small hardware return-address stack.
- Enters a sticky fault state on return-stack overflow or underflow.

Parameters:
ADDR_WIDTH, 8, width of PC, Target and return-stack entries
STACK_DEPTH, 4, number of return-stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Stall  input  1  1 = hold all state this cycle; Op ignored
Op  input  2  00 = sequential, 01 = conditional branch, 10 = call, 11 = return
Cond_Result  input  1  condition evaluator Result; used only when Op=01
Target  input  ADDR_WIDTH  jump target (register 0 value) for branch and call
PC  output  ADDR_WIDTH  current fetch address (registered)
Fetch_Valid  output  1  1 = PC is valid for fetch this cycle
Taken  output  1  registered one-cycle pulse: previous cycle redirected PC
Fault  output  1  sticky: stack overflow or underflow occurred
Fault_Code  output  2  00 = none, 01 = overflow, 10 = underflow (sticky, first fault wins)
Stack_Level  output  clog2(STACK_DEPTH)+1  current number of stacked entries

Behaviour:
Reset (rst=1 at an edge):
- PC=RESET_PC, Fetch_Valid=0, Taken=0, Fault=0, Fault_Code=00, Stack_Level=0, state=BOOT.
- Stack contents are don't-care.
- rst has priority over everything, including mid-call, mid-stall or FAULT.

FSM states:
- BOOT -> RUN unconditionally on the next edge.
  - Fetch_Valid=0 in BOOT, 1 in RUN, 0 in FAULT.
  - PC is not advanced in BOOT; the first fetch in RUN uses RESET_PC.
- RUN: evaluated each edge when Stall=0 (next-PC arithmetic is mod 2^ADDR_WIDTH, so PC=max+1 wraps to 0).
  - Op=00: PC<=PC+1, Taken<=0.
  - Op=01, Cond_Result=1: PC<=Target, Taken<=1.
  - Op=01, Cond_Result=0: PC<=PC+1, Taken<=0.
  - Op=10, Stack_Level<STACK_DEPTH: push PC+1 (wrapped), PC<=Target, Stack_Level+1, Taken<=1.
  - Op=10, stack full: no push, PC unchanged, Fault<=1, Fault_Code<=01, state<=FAULT, Taken<=0.
  - Op=11, Stack_Level>0: PC<=top entry, pop, Stack_Level-1, Taken<=1.
  - Op=11, stack empty: PC unchanged, Fault<=1, Fault_Code<=10, state<=FAULT, Taken<=0.
- RUN with Stall=1: PC, stack and Stack_Level hold, Taken<=0, Fetch_Valid stays 1.
- FAULT: terminal until rst. PC and stack frozen; Stall, Op and Cond_Result ignored; Taken=0.

Latency and ordering:
- A decision made in cycle N appears on PC in cycle N+1.
- Cond_Result is sampled in the same cycle as Op; there is no internal pipelining of the condition.
- Stack is LIFO. Call and return are never simultaneous because Op is encoded.
- Push and pop never occur in the same cycle, so a full stack at Op=11 pops normally.
- Stall=1 during BOOT is ignored (BOOT always exits after one cycle).

Test Plan:
- Reset, then Op=00 for 5 cycles with Stall=0 -> Fetch_Valid 0 then 1; PC sequence 0,0,1,2,3,4; Taken always 0.
- PC=0x10, Op=01, Target=0x80, Cond_Result=1 -> next PC=0x80, Taken=1 for exactly one cycle. Repeat with Cond_Result=0 -> PC=0x11, Taken=0.
- PC=0x20, Op=10, Target=0x40, then Op=00 twice, then Op=11 -> PC 0x40,0x41,0x42,0x21; Stack_Level 1,1,1,0.
- Five calls with STACK_DEPTH=4 -> 4th call gives Stack_Level=4; 5th gives Fault=1, Fault_Code=01, PC frozen, Fetch_Valid=0. Later Op=11 has no effect. rst restores PC=0, Fault=0.
- Op=11 right after reset entry into RUN -> Fault_Code=10, PC stays 0. Also PC=0xFF with Op=00 -> PC=0x00; call at 0xFF pushes 0x00.
- Stall=1 for 3 cycles while Op=01, Cond_Result=1 -> PC holds, Taken=0. Release Stall with Op=00 -> PC+1. Also assert rst mid-stall -> PC=RESET_PC on the next edge.

Source files
------------

// File: rtl/overture_pc_unit.sv
// Program-counter stage fed by the condition evaluator. Chooses the next
// fetch address from sequential increment, conditional branch, call or
// return, and keeps return addresses in a small LIFO. A stack overflow or
// underflow parks the unit in a sticky FAULT state until reset.
module overture_pc_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Stall,
    input  logic [1:0]                       Op,
    input  logic                             Cond_Result,
    input  logic [ADDR_WIDTH-1:0]            Target,
    output logic [ADDR_WIDTH-1:0]            PC,
    output logic                             Fetch_Valid,
    output logic                             Taken,
    output logic                             Fault,
    output logic [1:0]                       Fault_Code,
    output logic [$clog2(STACK_DEPTH):0]     Stack_Level
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE    = 1;
    localparam logic [LVL_W-1:0]      LVL_ONE   = 1;
    localparam logic [LVL_W-1:0]      LVL_ZERO  = '0;
    localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(STACK_DEPTH);

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    taken_q, taken_d;
    logic [1:0]              code_q, code_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    push;

    logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [PTR_W-1:0]        push_idx;
    logic [PTR_W-1:0]        top_idx;

    // Wrapped increment and stack pointers derived from the current level.
    always_comb begin
        pc_inc   = pc_q + PC_ONE;
        push_idx = PTR_W'(level_q);
        top_idx  = PTR_W'(level_q - LVL_ONE);
    end

    // Next-state decision: one redirect or increment per unstalled RUN cycle.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        code_d  = code_q;
        level_d = level_q;
        push    = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!Stall) begin
                    unique case (Op)
                        OP_SEQ: pc_d = pc_inc;
                        OP_BR: begin
                            if (Cond_Result) begin
                                pc_d    = Target;
                                taken_d = 1'b1;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_CALL: begin
                            if (level_q < LVL_FULL) begin
                                push    = 1'b1;
                                pc_d    = Target;
                                level_d = level_q + LVL_ONE;
                                taken_d = 1'b1;
                            end else begin
                                code_d  = FC_OVF;
                                state_d = FAULT;
                            end
                        end
                        OP_RET: begin
                            if (level_q != LVL_ZERO) begin
                                pc_d    = stack_q[top_idx];
                                level_d = level_q - LVL_ONE;
                                taken_d = 1'b1;
                            end else begin
                                code_d  = FC_UNF;
                                state_d = FAULT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FAULT: ;
            default: state_d = FAULT;
        endcase
    end

    // Control and PC registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            code_q  <= FC_NONE;
            level_q <= LVL_ZERO;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            code_q  <= code_d;
            level_q <= level_d;
        end
    end

    // Return-address storage written on each successful call.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; entries above Stack_Level are
        // never read, so clearing them would only add reset fan-out.
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign PC          = pc_q;
    assign Fetch_Valid = (state_q == RUN);
    assign Taken       = taken_q;
    assign Fault       = (code_q != FC_NONE);
    assign Fault_Code  = code_q;
    assign Stack_Level = level_q;

endmodule

// File: tb/tb_overture_pc_unit.sv
// Bench for overture_pc_unit: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_overture_pc_unit;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Stall = 1'b0;
    logic [1:0]    Op = 2'b00;
    logic          Cond_Result = 1'b0;
    logic [AW-1:0] Target = '0;
    logic [AW-1:0] PC;
    logic          Fetch_Valid;
    logic          Taken;
    logic          Fault;
    logic [1:0]    Fault_Code;
    logic [2:0]    Stack_Level;

    overture_pc_unit #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .Op         (Op),
        .Cond_Result(Cond_Result),
        .Target     (Target),
        .PC         (PC),
        .Fetch_Valid(Fetch_Valid),
        .Taken      (Taken),
        .Fault      (Fault),
        .Fault_Code (Fault_Code),
        .Stack_Level(Stack_Level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = faulted.
    int m_mode  = 0;
    int m_pc    = 0;
    int m_taken = 0;
    int m_code  = 0;
    int m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of the architectural rules to the model.
    task automatic model_edge(input logic r, input logic s, input logic [1:0] o,
                              input logic c, input logic [AW-1:0] t);
        if (r) begin
            m_mode = 0; m_pc = 0; m_taken = 0; m_code = 0;
            m_stack.delete();
            return;
        end
        m_taken = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !s) begin
            if (o == 2'd0) begin
                m_pc = (m_pc + 1) & MASK;
            end else if (o == 2'd1) begin
                if (c) begin m_pc = int'(t); m_taken = 1; end
                else   m_pc = (m_pc + 1) & MASK;
            end else if (o == 2'd2) begin
                if (m_stack.size() < DEPTH) begin
                    m_stack.push_back((m_pc + 1) & MASK);
                    m_pc = int'(t); m_taken = 1;
                end else begin
                    m_code = 1; m_mode = 2;
                end
            end else begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back(); m_taken = 1;
                end else begin
                    m_code = 2; m_mode = 2;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("PC",          32'(PC),          32'(m_pc));
        check("Fetch_Valid", 32'(Fetch_Valid), 32'(m_mode == 1));
        check("Taken",       32'(Taken),       32'(m_taken));
        check("Fault",       32'(Fault),       32'(m_code != 0));
        check("Fault_Code",  32'(Fault_Code),  32'(m_code));
        check("Stack_Level", 32'(Stack_Level), 32'(m_stack.size()));
    endtask

    // Drive one cycle, advance the model at the edge, compare on the falling edge.
    task automatic step(input logic r, input logic s, input logic [1:0] o,
                        input logic c, input logic [AW-1:0] t);
        rst = r; Stall = s; Op = o; Cond_Result = c; Target = t;
        @(posedge clk);
        model_edge(r, s, o, c, t);
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_and_boot();
        step(1'b1, 1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 1'b0, 2'd0, 1'b0, '0);
    endtask

    task automatic jump_to(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 2'd1, 1'b1, a);
    endtask

    initial begin
        // Reset then five sequential cycles: PC 0,0,1,2,3,4.
        step(1'b1, 1'b0, 2'd0, 1'b0, '0);
        check("lit_reset_pc", 32'(PC), 32'h0);
        check("lit_reset_fv", 32'(Fetch_Valid), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 1'b0, '0);
        check("lit_seq_pc", 32'(PC), 32'h4);

        // Conditional branch taken, then not taken.
        jump_to(8'h10);
        step(1'b0, 1'b0, 2'd1, 1'b1, 8'h80);
        check("lit_br_pc", 32'(PC), 32'h80);
        check("lit_br_taken", 32'(Taken), 32'h1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        check("lit_br_pulse", 32'(Taken), 32'h0);
        jump_to(8'h10);
        step(1'b0, 1'b0, 2'd1, 1'b0, 8'h80);
        check("lit_nt_pc", 32'(PC), 32'h11);

        // Call, two sequential, return.
        jump_to(8'h20);
        step(1'b0, 1'b0, 2'd2, 1'b0, 8'h40);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        check("lit_call_pc", 32'(PC), 32'h42);
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
        check("lit_ret_pc", 32'(PC), 32'h21);
        check("lit_ret_lvl", 32'(Stack_Level), 32'h0);

        // Overflow on the fifth call, then frozen until reset.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd2, 1'b0, AW'(8'h50 + i));
        check("lit_full_lvl", 32'(Stack_Level), 32'h4);
        step(1'b0, 1'b0, 2'd2, 1'b0, 8'h60);
        check("lit_ovf_code", 32'(Fault_Code), 32'h1);
        check("lit_ovf_pc", 32'(PC), 32'h53);
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
        check("lit_clr_fault", 32'(Fault), 32'h0);

        // Underflow right after boot.
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
        check("lit_unf_code", 32'(Fault_Code), 32'h2);
        check("lit_unf_pc", 32'(PC), 32'h0);

        // Wrap at the top of the address space, including the pushed address.
        reset_and_boot();
        jump_to(8'hFF);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        check("lit_wrap_pc", 32'(PC), 32'h0);
        jump_to(8'hFF);
        step(1'b0, 1'b0, 2'd2, 1'b0, 8'h30);
        step(1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
        check("lit_wrap_ret", 32'(PC), 32'h0);

        // Stall holds a pending branch; reset during stall wins.
        jump_to(8'h35);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 1'b1, 8'h99);
        check("lit_stall_pc", 32'(PC), 32'h35);
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        check("lit_unstall_pc", 32'(PC), 32'h36);
        step(1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 2'd2, 1'b0, 8'h12);
        check("lit_rst_stall", 32'(PC), 32'h0);

        // Stall during boot is ignored.
        step(1'b0, 1'b1, 2'd3, 1'b0, 8'h00);
        check("lit_boot_stall", 32'(Fetch_Valid), 32'h1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            int          pick;
            logic [1:0]  op;
            pick = int'($urandom_range(0, 99));
            op   = (pick < 40) ? 2'd0 : (pick < 65) ? 2'd1 : (pick < 85) ? 2'd2 : 2'd3;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), op,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, MASK)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
